data_mem_ctrl: RTL and testbench

Wait-state memory controller between `mips_core` data port and a slow, handshaked data memory. It converts the core's single-cycle `mem_ren`/`mem_wen` strobes into a held request/acknowledge transaction and drives `ram_stall` back to the core until the access completes. A bus timeout returns a poison value and flags an error. A configurable one-word read buffer lets repeated reads to the same word complete without stalling.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/data_mem_ctrl_if.sv | 40 ++++
 rtl/dmc_read_buf.sv | 52 +++++
 rtl/data_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types and constants for the data memory controller.
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  // Controller states: wait for a core access, hold the bus request, hand data back
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmc_state_t;

  // Read data returned to the core when the memory never acknowledges
  localparam logic [31:0] DMC_POISON_DEFAULT = 32'hDEAD_BEEF;

  // Lowest address bit that selects a 32-bit word
  localparam int WORD_LSB = 2;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl_if
//  Purpose  : Core-side strobes and memory-side request/ack bus of the
//             data memory controller. The controller takes the slave view,
//             the environment (core + memory) the master view.
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_ctrl_if;

  // core data port
  logic        cs;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        ram_stall;

  // slow memory port
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        bus_err;

  modport slave (
    input  cs, mem_ren, mem_wen, mem_addr, mem_din, m_rdata, m_ack,
    output mem_dout, ram_stall, m_req, m_we, m_addr, m_wdata, bus_err
  );

  modport master (
    output cs, mem_ren, mem_wen, mem_addr, mem_din, m_rdata, m_ack,
    input  mem_dout, ram_stall, m_req, m_we, m_addr, m_wdata, bus_err
  );

endinterface : data_mem_ctrl_if
`default_nettype wire

// File: rtl/dmc_read_buf.sv
`default_nettype none
// ============================================================================
//  Module   : dmc_read_buf
//  Purpose  : One-entry read buffer {valid, word tag, data}. Filled by every
//             acknowledged read, patched by acknowledged writes to the same
//             word, cleared by a bus timeout. Lookup is combinational.
//             Only instantiated when DMC_READ_BUF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module dmc_read_buf
  import mem_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  i_upd_en,     // transaction acknowledged
  input  wire logic                  i_upd_we,     // acknowledged access was a write
  input  wire logic [31-WORD_LSB:0]  i_upd_tag,
  input  wire logic [31:0]           i_upd_data,
  input  wire logic                  i_inval,      // transaction timed out
  input  wire logic [31-WORD_LSB:0]  i_lookup_tag,
  output logic                       o_hit,
  output logic [31:0]                o_data
);

  logic                 r_valid;
  logic [31-WORD_LSB:0] r_tag;
  logic [31:0]          r_data;

  // Entry storage: timeout wins, reads replace the entry, writes patch a matching word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_upd_en) begin
      if (!i_upd_we) begin
        r_valid <= 1'b1;
        r_tag   <= i_upd_tag;
        r_data  <= i_upd_data;
      end else if (r_valid && (r_tag == i_upd_tag)) begin
        r_data  <= i_upd_data;
      end
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

endmodule : dmc_read_buf
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Purpose  : Wait-state controller between the core data port and a slow
//             req/ack data memory. Turns one-cycle core strobes into a held
//             request, stalls the core until ack or timeout, and returns
//             POISON with a bus_err pulse on timeout.
//             Optional feature macro: DMC_READ_BUF_EN (one-word read buffer
//             that lets repeated reads of the same word complete unstalled).
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] POISON  = DMC_POISON_DEFAULT
) (
  input  wire logic       clk,
  input  wire logic       rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] c_cnt_max  = {CW{1'b1}};

  dmc_state_t           r_state;
  dmc_state_t           w_state_nxt;
  logic [31-WORD_LSB:0] r_word;
  logic [31:0]          r_wdata;
  logic                 r_we;
  logic [CW-1:0]        r_cnt;
  logic [31:0]          r_rd_q;
  logic                 r_bus_err;

  logic w_acc;
  logic w_hit;
  logic w_start;
  logic w_stall;
  logic w_ack;
  logic w_timeout;
  logic w_unused_ok;

  // Byte offset bits never reach the word-addressed memory
  assign w_unused_ok = &{1'b0, bus.mem_addr[WORD_LSB-1:0]};

  assign w_acc = bus.cs & (bus.mem_ren | bus.mem_wen);

  // m_ack only counts while a request is outstanding
  assign w_ack = (r_state == REQ) && bus.m_ack;

  // Timeout fires in the TIMEOUT-th REQ cycle unless that same cycle is acked
  assign w_timeout = (TIMEOUT != 0) && (r_state == REQ) && !bus.m_ack &&
                     (r_cnt == c_cnt_last);

`ifdef DMC_READ_BUF_EN
  logic        w_buf_hit;
  logic [31:0] w_buf_data;

  dmc_read_buf u_read_buf (
    .clk          (clk),
    .rst          (rst),
    .i_upd_en     (w_ack),
    .i_upd_we     (r_we),
    .i_upd_tag    (r_word),
    .i_upd_data   (r_we ? r_wdata : bus.m_rdata),
    .i_inval      (w_timeout),
    .i_lookup_tag (bus.mem_addr[31:WORD_LSB]),
    .o_hit        (w_buf_hit),
    .o_data       (w_buf_data)
  );

  // A pure read (write has priority) of the buffered word completes in IDLE
  assign w_hit = (r_state == IDLE) && bus.cs && bus.mem_ren && !bus.mem_wen && w_buf_hit;
  assign bus.mem_dout = w_hit ? w_buf_data : r_rd_q;
`else
  assign w_hit = 1'b0;
  assign bus.mem_dout = r_rd_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and stall/launch decode
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc && !w_hit) begin
          w_stall     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_stall = 1'b1;
        if (w_ack || w_timeout) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the request fields when an access is launched; held through REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_start) begin
      r_word  <= bus.mem_addr[31:WORD_LSB];
      r_wdata <= bus.mem_din;
      r_we    <= bus.mem_wen;
    end
  end

  // Wait counter: cleared on entry to REQ, counts REQ cycles, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == REQ) && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Read-data register; a buffer hit is copied in so the value holds afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_q <= '0;
    end else if (w_ack && !r_we) begin
      r_rd_q <= bus.m_rdata;
    end else if (w_timeout) begin
      r_rd_q <= POISON;
`ifdef DMC_READ_BUF_EN
    end else if (w_hit) begin
      r_rd_q <= w_buf_data;
`endif
    end
  end

  // bus_err lands in the DONE cycle that follows a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bus_err <= 1'b0;
    else     r_bus_err <= w_timeout;
  end

  assign bus.ram_stall = w_stall & ~rst;
  assign bus.m_req     = (r_state == REQ);
  assign bus.m_we      = r_we;
  assign bus.m_addr    = {r_word, {WORD_LSB{1'b0}}};
  assign bus.m_wdata   = r_wdata;
  assign bus.bus_err   = r_bus_err;

endmodule : data_mem_ctrl
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Purpose  : Self-checking bench for data_mem_ctrl with a transaction-level
//             reference model (read-back value, one-word buffer state).
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;
  import mem_pkg::*;

  localparam int TO = 4;
`ifdef DMC_READ_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.TIMEOUT(TO), .POISON(DMC_POISON_DEFAULT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] mdl_dout;
  bit          buf_v;
  logic [29:0] buf_tag;
  logic [31:0] buf_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cs      = 1'b0;
    bus.mem_ren = 1'b0;
    bus.mem_wen = 1'b0;
    bus.m_ack   = 1'b0;
  endtask

  // One core access; entered and left at posedge+1 of an IDLE cycle.
  // lat = REQ cycle in which memory acks (1..TO), 0 = never acks.
  task automatic do_access(input bit wen, input bit ren, input logic [31:0] addr,
                           input logic [31:0] din, input int lat, input logic [31:0] rdata);
    bit hit;
    bit tmo;
    int nreq;
    int stall_obs;
    hit  = BUF_EN && !wen && ren && buf_v && (buf_tag == addr[31:2]);
    tmo  = (lat == 0);
    nreq = tmo ? TO : lat;
    bus.cs = 1'b1; bus.mem_wen = wen; bus.mem_ren = ren;
    bus.mem_addr = addr; bus.mem_din = din;
    #1;
    if (hit) begin
      chk("hit_stall", {31'd0, bus.ram_stall}, 32'd0);
      chk("hit_req",   {31'd0, bus.m_req},     32'd0);
      chk("hit_dout",  bus.mem_dout, buf_data);
      mdl_dout = buf_data;
      tick();
      drive_idle();
      #1;
      chk("hit_after_req",  {31'd0, bus.m_req}, 32'd0);
      chk("hit_after_dout", bus.mem_dout, mdl_dout);
      return;
    end
    chk("idle_stall", {31'd0, bus.ram_stall}, 32'd1);
    chk("idle_req",   {31'd0, bus.m_req},     32'd0);
    stall_obs = int'(bus.ram_stall);
    tick();
    // garbage on the core port during REQ must not disturb the latched request
    bus.cs = 1'($urandom); bus.mem_ren = 1'($urandom); bus.mem_wen = 1'($urandom);
    bus.mem_addr = $urandom; bus.mem_din = $urandom;
    for (int k = 1; k <= nreq; k++) begin
      #1;
      chk("req_m_req", {31'd0, bus.m_req}, 32'd1);
      chk("req_addr",  bus.m_addr, {addr[31:2], 2'b00});
      chk("req_we",    {31'd0, bus.m_we}, {31'd0, wen});
      if (wen) chk("req_wdata", bus.m_wdata, din);
      chk("req_dout_hold", bus.mem_dout, mdl_dout);
      stall_obs += int'(bus.ram_stall);
      if (k == lat) begin
        bus.m_ack = 1'b1; bus.m_rdata = rdata;
      end
      if (k == nreq) begin
        bus.cs = 1'b0; bus.mem_ren = 1'b0; bus.mem_wen = 1'b0;
      end
      tick();
      bus.m_ack = 1'b0; bus.m_rdata = $urandom;
    end
    // reference: outcome of the finished transaction
    if (tmo) begin
      mdl_dout = DMC_POISON_DEFAULT;
      buf_v = 1'b0;
    end else if (!wen) begin
      mdl_dout = rdata;
      buf_v = 1'b1; buf_tag = addr[31:2]; buf_data = rdata;
    end else if (buf_v && buf_tag == addr[31:2]) begin
      buf_data = din;
    end
    chk("stall_cycles", stall_obs, 1 + nreq);
    chk("done_stall", {31'd0, bus.ram_stall}, 32'd0);
    chk("done_req",   {31'd0, bus.m_req},     32'd0);
    chk("done_err",   {31'd0, bus.bus_err},   {31'd0, tmo});
    chk("done_dout",  bus.mem_dout, mdl_dout);
    tick();
    chk("post_err",   {31'd0, bus.bus_err},   32'd0);
    chk("post_stall", {31'd0, bus.ram_stall}, 32'd0);
    chk("post_dout",  bus.mem_dout, mdl_dout);
  endtask

  // Idle cycles: core not accessing (cs low or no strobe), stray m_ack pulses
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cs = 1'($urandom);
      if (bus.cs) begin
        bus.mem_ren = 1'b0; bus.mem_wen = 1'b0;
      end else begin
        bus.mem_ren = 1'($urandom); bus.mem_wen = 1'($urandom);
      end
      bus.mem_addr = $urandom; bus.m_ack = 1'($urandom); bus.m_rdata = $urandom;
      #1;
      chk("idle_nostall", {31'd0, bus.ram_stall}, 32'd0);
      chk("idle_noreq",   {31'd0, bus.m_req},     32'd0);
      tick();
      chk("idle_dout",    bus.mem_dout, mdl_dout);
      chk("idle_noerr",   {31'd0, bus.bus_err},   32'd0);
    end
    drive_idle();
  endtask

  initial begin
    logic [31:0] a;
    bit w;
    mdl_dout = 32'd0; buf_v = 1'b0; buf_tag = '0; buf_data = '0;
    drive_idle();
    bus.mem_addr = 32'd0; bus.mem_din = 32'd0; bus.m_rdata = 32'd0;
    rst = 1'b1;
    // strobes active during reset must not stall
    bus.cs = 1'b1; bus.mem_ren = 1'b1;
    tick(); tick();
    chk("rst_stall", {31'd0, bus.ram_stall}, 32'd0);
    chk("rst_req",   {31'd0, bus.m_req},     32'd0);
    chk("rst_we",    {31'd0, bus.m_we},      32'd0);
    chk("rst_err",   {31'd0, bus.bus_err},   32'd0);
    chk("rst_addr",  bus.m_addr,  32'd0);
    chk("rst_wdata", bus.m_wdata, 32'd0);
    chk("rst_dout",  bus.mem_dout, 32'd0);
    drive_idle();
    rst = 1'b0;
    tick();

    // read, ack in REQ cycle 3
    do_access(1'b0, 1'b1, 32'h0000_0104, 32'h0, 3, 32'h1234_5678);
    // ren and wen together act as a write
    do_access(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1, 32'hFFFF_0000);
    // timeout on a read
    do_access(1'b0, 1'b1, 32'h0000_0300, 32'h0, 0, 32'h0);
    // ack exactly in the last allowed cycle
    do_access(1'b0, 1'b1, 32'h0000_0303, 32'h0, TO, 32'h0BAD_F00D);

    // reset in REQ cycle 2
    bus.cs = 1'b1; bus.mem_ren = 1'b1; bus.mem_addr = 32'h0000_0080;
    tick();
    drive_idle();
    tick();
    chk("rstmid_req_before", {31'd0, bus.m_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_req",   {31'd0, bus.m_req},     32'd0);
    chk("rstmid_stall", {31'd0, bus.ram_stall}, 32'd0);
    tick();
    rst = 1'b0;
    mdl_dout = 32'd0; buf_v = 1'b0;
    bus.m_ack = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    tick();
    bus.m_ack = 1'b0;
    tick();
    chk("late_ack_dout",  bus.mem_dout, 32'd0);
    chk("late_ack_err",   {31'd0, bus.bus_err}, 32'd0);
    chk("late_ack_req",   {31'd0, bus.m_req},   32'd0);
    idle_cycles(3);

    // buffered word: fill, hit, patch by write, hit again
    do_access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 2, 32'h0000_0011);
    do_access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 1, 32'h0000_0099);
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0000_0022, 2, 32'h0);
    do_access(1'b0, 1'b1, 32'h0000_0042, 32'h0, 3, 32'h0000_0077);

    // back-to-back reads of neighbouring words
    do_access(1'b0, 1'b1, 32'h0000_0000, 32'h0, 1, 32'hCAFE_0000);
    do_access(1'b0, 1'b1, 32'h0000_0004, 32'h0, 1, 32'hCAFE_0004);

    // randomized traffic over a small set of words so the buffer gets reused
    for (int t = 0; t < 150; t++) begin
      a = {26'd0, 4'($urandom_range(0, 7)), 2'($urandom)};
      w = ($urandom_range(0, 2) == 0);
      do_access(w, w ? 1'($urandom) : 1'b1, a, $urandom,
                $urandom_range(0, TO), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // absolute guard so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_data_mem_ctrl
`default_nettype wire
